seq_alu_param: RTL and testbench

- Parametrised, clocked successor to the team's 16-bit structural ALU: same 3-bit opcode space, same carry-in, negative and zero semantics.
- Adds registered operands, a start/busy/done handshake, a carry/overflow flag, and two multi-cycle operations: bit-serial shift and shift-add multiply.
- Sits between the datapath register file and the writeback stage; one operation in flight at a time.

---
 rtl/seq_alu_param_if.sv | 31 +++
 rtl/seq_alu_param.sv | 192 +++++++++++++++++++
 tb/tb_seq_alu_param.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_param_if.sv
`default_nettype none
// ============================================================================
// seq_alu_param_if : start/busy/done handshake and operand/result bundle
// Rev 1.0
// ============================================================================
interface seq_alu_param_if #(
   parameter int WIDTH = 16
) ();
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             c;
   logic [2:0]       opc;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] W;
   logic             neg;
   logic             zer;
   logic             cout;

   modport master (
      output start, A, B, c, opc,
      input  busy, done, W, neg, zer, cout
   );

   modport slave (
      input  start, A, B, c, opc,
      output busy, done, W, neg, zer, cout
   );
endinterface
`default_nettype wire

// File: rtl/seq_alu_param.sv
`default_nettype none
// ============================================================================
// seq_alu_param : clocked ALU with handshake, serial shift and shift-add mul
// Rev 1.0
// ============================================================================
module seq_alu_param #(
   parameter int  WIDTH = 16,
   localparam int SW    = $clog2(WIDTH)
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   seq_alu_param_if.slave bus
);
   // counter must reach WIDTH for the multiply, so one bit wider than SW
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OPC_ADD = 3'b000;
   localparam logic [2:0] OPC_SUB = 3'b001;
   localparam logic [2:0] OPC_AND = 3'b010;
   localparam logic [2:0] OPC_OR  = 3'b011;
   localparam logic [2:0] OPC_XOR = 3'b100;
   localparam logic [2:0] OPC_NOT = 3'b101;
   localparam logic [2:0] OPC_SHL = 3'b110;
   localparam logic [2:0] OPC_MUL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_MUL   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               c_q, c_d;
   logic [2:0]         opc_q, opc_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               sh_out_q, sh_out_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   w_q, w_d;
   logic               neg_q, neg_d;
   logic               zer_q, zer_d;
   logic               cout_q, cout_d;

   logic               finish;
   logic [WIDTH-1:0]   res;
   logic               res_cout;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_diff;
   logic [WIDTH:0]     mul_sum;

   always_comb begin
      add_sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_q};
      sub_diff = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, c_q};
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);

      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      opc_d    = opc_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sh_out_d = sh_out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      w_d      = w_q;
      neg_d    = neg_q;
      zer_d    = zer_q;
      cout_d   = cout_q;
      finish   = 1'b0;
      res      = '0;
      res_cout = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d      = bus.A;
               b_d      = bus.B;
               c_d      = bus.c;
               opc_d    = bus.opc;
               busy_d   = 1'b1;
               sh_out_d = 1'b0;
               case (bus.opc)
                  OPC_SHL: begin
                     state_d = ST_SHIFT;
                     acc_d   = {{WIDTH{1'b0}}, bus.A};
                     cnt_d   = CW'(bus.B[SW-1:0]);
                  end
                  OPC_MUL: begin
                     // high half accumulates partial products, low half holds the multiplier
                     state_d = ST_MUL;
                     acc_d   = {{WIDTH{1'b0}}, bus.B};
                     cnt_d   = CW'(WIDTH);
                  end
                  default: state_d = ST_EXEC;
               endcase
            end
         end
         ST_EXEC: begin
            finish = 1'b1;
            case (opc_q)
               OPC_ADD: begin res = add_sum[WIDTH-1:0];  res_cout = add_sum[WIDTH];  end
               OPC_SUB: begin res = sub_diff[WIDTH-1:0]; res_cout = sub_diff[WIDTH]; end
               OPC_AND: res = a_q & b_q;
               OPC_OR:  res = a_q | b_q;
               OPC_XOR: res = a_q ^ b_q;
               OPC_NOT: res = ~a_q;
               default: res = '0;
            endcase
         end
         ST_SHIFT: begin
            if (cnt_q == '0) begin
               finish   = 1'b1;
               res      = acc_q[WIDTH-1:0];
               res_cout = sh_out_q;
            end else begin
               acc_d    = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], 1'b0};
               sh_out_d = acc_q[WIDTH-1];
               cnt_d    = cnt_q - 1'b1;
            end
         end
         ST_MUL: begin
            if (cnt_q == '0) begin
               finish   = 1'b1;
               res      = acc_q[WIDTH-1:0];
               res_cout = |acc_q[2*WIDTH-1:WIDTH];
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // only the completion edge touches the visible result
      if (finish) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b1;
         w_d     = res;
         neg_d   = res[WIDTH-1];
         zer_d   = (res == '0);
         cout_d  = res_cout;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         opc_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sh_out_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         w_q      <= '0;
         neg_q    <= 1'b0;
         zer_q    <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         opc_q    <= opc_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sh_out_q <= sh_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         w_q      <= w_d;
         neg_q    <= neg_d;
         zer_q    <= zer_d;
         cout_q   <= cout_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.W    = w_q;
   assign bus.neg  = neg_q;
   assign bus.zer  = zer_q;
   assign bus.cout = cout_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu_param.sv
`default_nettype none
// ============================================================================
// tb_seq_alu_param : vector table, handshake/reset sequences, random vs model
// Rev 1.0
// ============================================================================
module tb_seq_alu_param;
   localparam int WIDTH   = 16;
   localparam int LAT_MAX = 64;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   seq_alu_param_if #(.WIDTH(WIDTH)) bus ();

   seq_alu_param #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]       opc;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             c;
      logic [WIDTH-1:0] w;
      logic             neg;
      logic             zer;
      logic             cout;
      int               lat;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the opcode rules
   function automatic void ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic cin, input logic [2:0] op,
                                     output logic [WIDTH-1:0] w, output logic co, output int lat);
      longint unsigned la, lb, lc, full;
      int n;
      la  = 64'(a);
      lb  = 64'(b);
      lc  = 64'(cin);
      lat = 1;
      co  = 1'b0;
      full = 0;
      case (op)
         3'd0: begin full = la + lb + lc; co = ((full >> WIDTH) != 0); end
         3'd1: begin full = la - lb - lc; co = (la < lb + lc); end
         3'd2: full = la & lb;
         3'd3: full = la | lb;
         3'd4: full = la ^ lb;
         3'd5: full = ~la;
         3'd6: begin
            n    = int'(lb % WIDTH);
            full = la << n;
            co   = (n == 0) ? 1'b0 : 1'((la >> (WIDTH - n)) & 1);
            lat  = n + 1;
         end
         default: begin
            full = la * lb;
            co   = ((full >> WIDTH) != 0);
            lat  = WIDTH + 1;
         end
      endcase
      w = full[WIDTH-1:0];
   endfunction

   task automatic run_and_check(input string name,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic [2:0] op,
                                input logic [WIDTH-1:0] ew, input logic eneg, input logic ezer,
                                input logic ecout, input int elat);
      int lat;
      bit seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.c     = cin;
      bus.opc   = op;
      @(posedge clk); #1;
      check({name, "_busy_acc"}, 64'(bus.busy), 64'd1);
      // inputs changing while busy must not disturb the operation
      bus.start = 1'b0;
      bus.A     = ~a;
      bus.B     = ~b;
      bus.c     = ~cin;
      bus.opc   = ~op;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < LAT_MAX) begin
         @(posedge clk); #1;
         lat++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check({name, "_lat"},  64'(lat),       64'(elat));
      check({name, "_W"},    64'(bus.W),     64'(ew));
      check({name, "_neg"},  64'(bus.neg),   64'(eneg));
      check({name, "_zer"},  64'(bus.zer),   64'(ezer));
      check({name, "_cout"}, 64'(bus.cout),  64'(ecout));
      check({name, "_busy_done"}, 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      check({name, "_done_1cyc"}, 64'(bus.done), 64'd0);
      check({name, "_W_hold"},    64'(bus.W),    64'(ew));
   endtask

   initial begin
      int lat;
      int pulses;
      bit seen;
      logic [WIDTH-1:0] ra, rb, ew;
      logic rc, eco;
      int elat;

      vecs[0]  = '{3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1};
      vecs[1]  = '{3'b001, 16'h0003, 16'h0005, 1'b1, 16'hFFFD, 1'b1, 1'b0, 1'b1, 1};
      vecs[2]  = '{3'b100, 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
      vecs[3]  = '{3'b010, 16'h00FF, 16'h0F0F, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 1};
      vecs[4]  = '{3'b011, 16'hF000, 16'h000F, 1'b0, 16'hF00F, 1'b1, 1'b0, 1'b0, 1};
      vecs[5]  = '{3'b101, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1};
      vecs[6]  = '{3'b110, 16'h8001, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 4};
      vecs[7]  = '{3'b110, 16'h8001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 2};
      vecs[8]  = '{3'b110, 16'h8001, 16'h0010, 1'b0, 16'h8001, 1'b1, 1'b0, 1'b0, 1};
      vecs[9]  = '{3'b111, 16'h0123, 16'h0010, 1'b0, 16'h1230, 1'b0, 1'b0, 1'b0, 17};
      vecs[10] = '{3'b111, 16'h1000, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 17};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.c     = 1'b0;
      bus.opc   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_W",    64'(bus.W),    64'd0);
      check("rst_neg",  64'(bus.neg),  64'd0);
      check("rst_zer",  64'(bus.zer),  64'd0);
      check("rst_cout", 64'(bus.cout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++)
         run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].opc,
                       vecs[i].w, vecs[i].neg, vecs[i].zer, vecs[i].cout, vecs[i].lat);

      // start held through a MUL, then a queued ADD accepted in the done cycle
      @(negedge clk);
      bus.start = 1'b1;
      bus.opc   = 3'b111;
      bus.A     = 16'h0003;
      bus.B     = 16'h0005;
      bus.c     = 1'b0;
      @(posedge clk); #1;
      check("b2b_busy_acc", 64'(bus.busy), 64'd1);
      bus.opc = 3'b000;
      bus.A   = 16'h0001;
      bus.B   = 16'h0002;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < LAT_MAX) begin
         @(posedge clk); #1;
         lat++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check("b2b_mul_lat", 64'(lat),      64'd17);
      check("b2b_mul_W",   64'(bus.W),    64'h000F);
      check("b2b_mul_busy",64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      check("b2b_add_busy", 64'(bus.busy), 64'd1);
      check("b2b_add_done0",64'(bus.done), 64'd0);
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("b2b_add_done", 64'(bus.done), 64'd1);
      check("b2b_add_W",    64'(bus.W),    64'h0003);

      // reset at t+5 of a MUL
      @(negedge clk);
      bus.start = 1'b1;
      bus.opc   = 3'b111;
      bus.A     = 16'h00FF;
      bus.B     = 16'h00FF;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mrst_busy", 64'(bus.busy), 64'd0);
      check("mrst_done", 64'(bus.done), 64'd0);
      check("mrst_W",    64'(bus.W),    64'd0);
      check("mrst_neg",  64'(bus.neg),  64'd0);
      check("mrst_zer",  64'(bus.zer),  64'd0);
      check("mrst_cout", 64'(bus.cout), 64'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.done !== 1'b0) pulses++;
      end
      check("mrst_no_done", 64'(pulses), 64'd0);
      run_and_check("post_rst", 16'hFFFF, 16'h0001, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b1, 1'b1, 1);

      for (int it = 0; it < 6; it++) begin
         for (int op = 0; op < 8; op++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            ref_model(ra, rb, rc, 3'(op), ew, eco, elat);
            run_and_check($sformatf("rnd%0d_op%0d", it, op), ra, rb, rc, 3'(op),
                          ew, ew[WIDTH-1], (ew == '0), eco, elat);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
